mmio_io_hub: RTL and testbench

MMIO_IO_HUB -- requirements
Module: mmio_io_hub

---
 rtl/mmio_io_hub.sv | 207 ++++++++++++++++++++
 tb/tb_mmio_io_hub.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_hub.sv
// mmio_io_hub -- memory-mapped I/O hub sitting beside the processor's data RAM.
//
// Addresses whose upper 20 bits equal IO_BASE are claimed by the hub; all other
// accesses go to RAM. I/O reads are registered so they line up with the RAM's
// one-cycle read latency.
//
// Register map (address_dmem[11:0]):
//   0 LED        RW  LED_W bits, drives LED directly
//   1 SW         RO  debounced switch state
//   2 STATUS     RW1C bit 0 = sticky "switch changed"
//   3 TIMER      RW  free-running tick counter      (IO_TIMER_EN only)
//   4 TIMER_DIV  RW  prescaler divide, 0 = stopped  (IO_TIMER_EN only)
//   other offsets read 0, writes ignored.
//
// Build option: define IO_TIMER_EN to include TIMER / TIMER_DIV / prescaler.
// Without it, offsets 3 and 4 behave as unmapped.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   wren         processor data-memory write enable
//   address_dmem processor data-memory address
//   data         processor write data
//   q_dmem       read data back to processor (RAM or I/O, one-cycle latency)
//   ram_wEn      write enable forwarded to RAM (suppressed for I/O addresses)
//   ram_dataOut  synchronous-read RAM data
//   SW           asynchronous board switches
//   LED          board LEDs
module mmio_io_hub #(
   parameter int          LED_W        = 16,
   parameter int          SW_W         = 5,
   parameter int          DEBOUNCE_CYC = 4,
   parameter logic [19:0] IO_BASE      = 20'h00001
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wren,
   input  logic [31:0]       address_dmem,
   input  logic [31:0]       data,
   output logic [31:0]       q_dmem,
   output logic              ram_wEn,
   input  logic [31:0]       ram_dataOut,
   input  logic [SW_W-1:0]   SW,
   output logic [LED_W-1:0]  LED
);

   localparam logic [11:0] OFF_LED    = 12'd0;
   localparam logic [11:0] OFF_SW     = 12'd1;
   localparam logic [11:0] OFF_STATUS = 12'd2;
   localparam logic [11:0] OFF_TIMER  = 12'd3;
   localparam logic [11:0] OFF_DIV    = 12'd4;

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYC - 1);

   logic              io_sel;
   logic              io_wr;
   logic [11:0]       offset;
   logic [LED_W-1:0]  led_reg;
   logic [SW_W-1:0]   sw_meta;
   logic [SW_W-1:0]   sw_sync;
   logic [SW_W-1:0]   sw_stable;
   logic [SW_W-1:0]   sw_stable_next;
   logic [15:0]       db_cnt      [SW_W];
   logic [15:0]       db_cnt_next [SW_W];
   logic              sw_change;
   logic              status;
   logic [31:0]       timer_val;
   logic [31:0]       div_val;
   logic [31:0]       io_rdata;
   logic [31:0]       io_rdata_q;
   logic              io_sel_q;

   // Address decode; RAM write gating is purely combinational and ignores reset.
   assign io_sel  = (address_dmem[31:12] == IO_BASE);
   assign offset  = address_dmem[11:0];
   assign ram_wEn = wren & ~io_sel;
   assign io_wr   = wren & io_sel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         led_reg <= '0;
      end else if (io_wr && offset == OFF_LED) begin
         led_reg <= data[LED_W-1:0];
      end
   end

   assign LED = led_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= SW;
         sw_sync <= sw_meta;
      end
   end

   // Per-bit debounce: the counter only runs while the synchronised input
   // disagrees with the accepted state; DEBOUNCE_CYC consecutive disagreeing
   // samples flip the accepted state.
   always_comb begin
      for (int i = 0; i < SW_W; i++) begin
         sw_stable_next[i] = sw_stable[i];
         db_cnt_next[i]    = '0;
         if (sw_sync[i] != sw_stable[i]) begin
            if (db_cnt[i] == DB_LAST) begin
               sw_stable_next[i] = ~sw_stable[i];
            end else begin
               db_cnt_next[i] = db_cnt[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_stable <= '0;
         for (int i = 0; i < SW_W; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sw_stable <= sw_stable_next;
         for (int i = 0; i < SW_W; i++) begin
            db_cnt[i] <= db_cnt_next[i];
         end
      end
   end

   assign sw_change = |(sw_stable_next ^ sw_stable);

   // Sticky change flag; a new change on the clearing edge keeps it set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status <= 1'b0;
      end else if (sw_change) begin
         status <= 1'b1;
      end else if (io_wr && offset == OFF_STATUS && data[0]) begin
         status <= 1'b0;
      end
   end

`ifdef IO_TIMER_EN
   logic [31:0] timer;
   logic [31:0] timer_div;
   logic [31:0] presc;
   logic        tick;

   assign tick = (timer_div != 32'd0) && (presc == timer_div - 32'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer     <= '0;
         timer_div <= '0;
         presc     <= '0;
      end else begin
         if (io_wr && offset == OFF_DIV) begin
            timer_div <= data;
            presc     <= '0;
         end else if (timer_div != 32'd0) begin
            presc <= tick ? 32'd0 : presc + 32'd1;
         end
         // A software write overrides a coincident increment.
         if (io_wr && offset == OFF_TIMER) begin
            timer <= data;
         end else if (tick) begin
            timer <= timer + 32'd1;
         end
      end
   end

   assign timer_val = timer;
   assign div_val   = timer_div;
`else
   logic unused_data;

   assign unused_data = ^data;
   assign timer_val   = '0;
   assign div_val     = '0;
`endif

   always_comb begin
      io_rdata = '0;
      case (offset)
         OFF_LED:    io_rdata[LED_W-1:0] = led_reg;
         OFF_SW:     io_rdata[SW_W-1:0]  = sw_stable;
         OFF_STATUS: io_rdata[0]         = status;
         OFF_TIMER:  io_rdata            = timer_val;
         OFF_DIV:    io_rdata            = div_val;
         default:    io_rdata            = '0;
      endcase
   end

   // Read pipeline: I/O data and source select registered to match RAM latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_sel_q   <= 1'b0;
         io_rdata_q <= '0;
      end else begin
         io_sel_q   <= io_sel;
         io_rdata_q <= io_rdata;
      end
   end

   assign q_dmem = io_sel_q ? io_rdata_q : ram_dataOut;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed testbench for mmio_io_hub with default parameters.
module tb_mmio_io_hub;

   localparam logic [19:0] IOB        = 20'h00001;
   localparam logic [11:0] OFF_LED    = 12'd0;
   localparam logic [11:0] OFF_SW     = 12'd1;
   localparam logic [11:0] OFF_STATUS = 12'd2;
   localparam logic [11:0] OFF_TIMER  = 12'd3;
   localparam logic [11:0] OFF_DIV    = 12'd4;

   logic        clock = 1'b0;
   logic        reset;
   logic        wren;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic [31:0] q_dmem;
   logic        ram_wEn;
   logic [31:0] ram_dataOut;
   logic [4:0]  SW;
   logic [15:0] LED;

   int checks   = 0;
   int failures = 0;

   mmio_io_hub dut (
      .clock        (clock),
      .reset        (reset),
      .wren         (wren),
      .address_dmem (address_dmem),
      .data         (data),
      .q_dmem       (q_dmem),
      .ram_wEn      (ram_wEn),
      .ram_dataOut  (ram_dataOut),
      .SW           (SW),
      .LED          (LED)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic io_write(input logic [11:0] off, input logic [31:0] val);
      address_dmem = {IOB, off};
      data         = val;
      wren         = 1'b1;
      cyc();
      wren         = 1'b0;
   endtask

   task automatic io_read(input logic [11:0] off, output logic [31:0] val);
      address_dmem = {IOB, off};
      wren         = 1'b0;
      cyc();
      val = q_dmem;
   endtask

   logic [31:0] rd;
   logic [31:0] ram_addr_tab [5];
   logic [31:0] exp_tab      [5];

   initial begin
      reset        = 1'b1;
      wren         = 1'b1;
      address_dmem = 32'h0000_0040;
      data         = 32'h0;
      ram_dataOut  = 32'h5A5A_5A5A;
      SW           = 5'b00000;
      #2;
      // Reset state and reset-independent RAM write gating
      check_eq("rst_led", 32'(LED), 32'h0);
      check_eq("rst_q_ram_path", q_dmem, 32'h5A5A_5A5A);
      check_eq("rst_ram_wen_ram_addr", 32'(ram_wEn), 32'h1);
      address_dmem = {IOB, OFF_LED};
      #1;
      check_eq("rst_ram_wen_io_addr", 32'(ram_wEn), 32'h0);
      wren = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc();

      // LED write / read back
      address_dmem = 32'h0000_1000;
      data         = 32'h0000_ABCD;
      wren         = 1'b1;
      #1;
      check_eq("io_wr_ram_wen", 32'(ram_wEn), 32'h0);
      check_eq("led_before_edge", 32'(LED), 32'h0);
      cyc();
      wren = 1'b0;
      check_eq("led_after_write", 32'(LED), 32'h0000_ABCD);
      io_read(OFF_LED, rd);
      check_eq("led_readback", rd, 32'h0000_ABCD);
      io_write(OFF_LED, 32'hFFFF_1234);
      io_read(OFF_LED, rd);
      check_eq("led_zero_ext", rd, 32'h0000_1234);

      // RAM write passes through, LED untouched
      address_dmem = 32'h0000_0010;
      data         = 32'h1234_5678;
      wren         = 1'b1;
      #1;
      check_eq("ram_wr_wen", 32'(ram_wEn), 32'h1);
      cyc();
      wren = 1'b0;
      check_eq("ram_wr_led_kept", 32'(LED), 32'h0000_1234);

      // Interleaved RAM / I/O reads
      ram_addr_tab[0] = {IOB, OFF_LED};    exp_tab[0] = 32'h0000_1234;
      ram_addr_tab[1] = 32'h0000_0020;     exp_tab[1] = 32'hC0DE_0001;
      ram_addr_tab[2] = {IOB, 12'd7};      exp_tab[2] = 32'h0;
      ram_addr_tab[3] = 32'h0000_0024;     exp_tab[3] = 32'hC0DE_0003;
      ram_addr_tab[4] = {IOB, OFF_STATUS}; exp_tab[4] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         address_dmem = ram_addr_tab[i];
         ram_dataOut  = 32'hC0DE_0000 + 32'(i);
         cyc();
         check_eq($sformatf("interleave_%0d", i), q_dmem, exp_tab[i]);
      end

      // Debounce: accepted 2 + 4 edges after the switch change
      address_dmem = {IOB, OFF_SW};
      SW = 5'b00101;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         if (k == 6) check_eq("sw_not_yet", q_dmem, 32'h0);
         if (k == 7) check_eq("sw_accepted", q_dmem, 32'h0000_0005);
      end
      io_read(OFF_STATUS, rd);
      check_eq("status_set", rd, 32'h1);
      io_write(OFF_STATUS, 32'h0);
      io_read(OFF_STATUS, rd);
      check_eq("status_kept_w0", rd, 32'h1);
      io_write(OFF_STATUS, 32'h1);
      io_read(OFF_STATUS, rd);
      check_eq("status_cleared", rd, 32'h0);

      // Three-cycle glitch is rejected
      SW = 5'b00111;
      repeat (3) cyc();
      SW = 5'b00101;
      repeat (8) cyc();
      io_read(OFF_SW, rd);
      check_eq("glitch_sw", rd, 32'h0000_0005);
      io_read(OFF_STATUS, rd);
      check_eq("glitch_status", rd, 32'h0);

      // Clear coinciding with a new change: set wins
      SW = 5'b00000;
      repeat (5) cyc();
      io_write(OFF_STATUS, 32'h1);
      io_read(OFF_STATUS, rd);
      check_eq("status_set_wins", rd, 32'h1);
      io_read(OFF_SW, rd);
      check_eq("sw_back_zero", rd, 32'h0);

`ifdef IO_TIMER_EN
      // Divide-by-3 ticking
      io_write(OFF_TIMER, 32'h0);
      io_write(OFF_DIV, 32'd3);
      address_dmem = {IOB, OFF_TIMER};
      for (int k = 1; k <= 7; k++) begin
         cyc();
         check_eq($sformatf("timer_div3_%0d", k), q_dmem, 32'((k - 1) / 3));
      end
      // Wrap and stop
      io_write(OFF_DIV, 32'd0);
      io_write(OFF_TIMER, 32'hFFFF_FFFF);
      io_write(OFF_DIV, 32'd1);
      io_read(OFF_TIMER, rd);
      check_eq("timer_max", rd, 32'hFFFF_FFFF);
      io_read(OFF_TIMER, rd);
      check_eq("timer_wrap", rd, 32'h0);
      io_write(OFF_DIV, 32'd0);
      io_read(OFF_TIMER, rd);
      check_eq("timer_stop_a", rd, 32'd2);
      io_read(OFF_TIMER, rd);
      check_eq("timer_stop_b", rd, 32'd2);
      // Write on a tick edge wins
      io_write(OFF_DIV, 32'd3);
      cyc();
      cyc();
      io_write(OFF_TIMER, 32'h100);
      io_read(OFF_TIMER, rd);
      check_eq("timer_wr_wins", rd, 32'h100);
      io_read(OFF_TIMER, rd);
      check_eq("timer_hold_a", rd, 32'h100);
      io_read(OFF_TIMER, rd);
      check_eq("timer_hold_b", rd, 32'h100);
      io_read(OFF_TIMER, rd);
      check_eq("timer_next_tick", rd, 32'h101);
      io_read(OFF_DIV, rd);
      check_eq("div_readback", rd, 32'd3);
`else
      // Timer offsets unmapped
      io_write(OFF_DIV, 32'd5);
      io_write(OFF_TIMER, 32'h77);
      io_read(OFF_TIMER, rd);
      check_eq("notimer_off3", rd, 32'h0);
      io_read(OFF_DIV, rd);
      check_eq("notimer_off4", rd, 32'h0);
`endif

      // Asynchronous reset mid-operation
      io_write(OFF_LED, 32'h0000_FFFF);
      io_read(OFF_LED, rd);
      check_eq("led_ffff", rd, 32'h0000_FFFF);
      ram_dataOut = 32'h5A5A_5A5A;
      SW = 5'b10010;
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_rst_led", 32'(LED), 32'h0);
      check_eq("async_rst_q", q_dmem, 32'h5A5A_5A5A);
      @(negedge clock);
      reset = 1'b0;
      io_read(OFF_STATUS, rd);
      check_eq("post_rst_status", rd, 32'h0);
      io_read(OFF_SW, rd);
      check_eq("post_rst_sw", rd, 32'h0);
      io_read(OFF_LED, rd);
      check_eq("post_rst_led", rd, 32'h0);
      io_read(OFF_TIMER, rd);
      check_eq("post_rst_timer", rd, 32'h0);
      io_read(OFF_DIV, rd);
      check_eq("post_rst_div", rd, 32'h0);
      repeat (4) cyc();
      io_read(OFF_SW, rd);
      check_eq("sw_requalified", rd, 32'h0000_0012);
      io_read(OFF_STATUS, rd);
      check_eq("status_after_requal", rd, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
